// File: rtl/bandpass_level_detector.sv
// rtl/bandpass_level_detector.sv - windowed max/min/pk2pk/mean-abs level detector
// with a one-entry result register that drops and counts results it cannot hold.
module bandpass_level_detector #(
  parameter int DATA_W   = 12,
  parameter int WIN_LOG2 = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     win_en,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_max,
  output logic signed [DATA_W-1:0] m_min,
  output logic [DATA_W:0]          m_pk2pk,
  output logic [DATA_W-1:0]        m_absavg,
  output logic [7:0]               drop_cnt
);

  localparam int ACC_W = DATA_W + WIN_LOG2;
  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] run_max;
  logic signed [DATA_W-1:0] run_min;
  logic [ACC_W-1:0]         acc;
  logic [WIN_LOG2-1:0]      cnt;

  logic                     accept;
  logic                     last;
  logic [DATA_W-1:0]        abs_x;
  logic signed [DATA_W-1:0] new_max;
  logic signed [DATA_W-1:0] new_min;
  logic [ACC_W-1:0]         acc_next;
  logic [DATA_W:0]          pk2pk_next;

  assign s_ready = (state == ACCUM) && win_en;
  assign accept  = s_valid && s_ready;
  assign last    = accept && (cnt == '1);

  // Negating the most negative code yields 2**(DATA_W-1), which is exact when read unsigned.
  assign abs_x      = s_data[DATA_W-1] ? $unsigned(-s_data) : $unsigned(s_data);
  assign new_max    = (s_data > run_max) ? s_data : run_max;
  assign new_min    = (s_data < run_min) ? s_data : run_min;
  assign acc_next   = acc + ACC_W'(abs_x);
  assign pk2pk_next = {new_max[DATA_W-1], new_max} - {new_min[DATA_W-1], new_min};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      run_max  <= MOST_NEG;
      run_min  <= MOST_POS;
      acc      <= '0;
      cnt      <= '0;
      m_valid  <= 1'b0;
      m_max    <= '0;
      m_min    <= '0;
      m_pk2pk  <= '0;
      m_absavg <= '0;
      drop_cnt <= '0;
    end else begin
      if (state == IDLE) begin
        if (win_en) begin
          state   <= ACCUM;
          run_max <= MOST_NEG;
          run_min <= MOST_POS;
          acc     <= '0;
          cnt     <= '0;
        end
      end else if (!win_en) begin
        state   <= IDLE;
        run_max <= MOST_NEG;
        run_min <= MOST_POS;
        acc     <= '0;
        cnt     <= '0;
      end else if (accept) begin
        if (last) begin
          run_max <= MOST_NEG;
          run_min <= MOST_POS;
          acc     <= '0;
          cnt     <= '0;
        end else begin
          run_max <= new_max;
          run_min <= new_min;
          acc     <= acc_next;
          cnt     <= cnt + 1'b1;
        end
      end

      // A completing window may replace a result that is being consumed on this edge.
      if (last) begin
        if (!m_valid || m_ready) begin
          m_valid  <= 1'b1;
          m_max    <= new_max;
          m_min    <= new_min;
          m_pk2pk  <= pk2pk_next;
          m_absavg <= acc_next[ACC_W-1 -: DATA_W];
        end else if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bandpass_level_detector.sv
// tb/tb_bandpass_level_detector.sv - directed and random checks of the level detector
// against a window-list reference model.
module tb_bandpass_level_detector;

  localparam int DATA_W   = 12;
  localparam int WIN_LOG2 = 2;
  localparam int WIN      = 1 << WIN_LOG2;

  logic                     clk;
  logic                     reset;
  logic                     win_en;
  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] s_data;
  logic                     m_valid;
  logic                     m_ready;
  logic signed [DATA_W-1:0] m_max;
  logic signed [DATA_W-1:0] m_min;
  logic [DATA_W:0]          m_pk2pk;
  logic [DATA_W-1:0]        m_absavg;
  logic [7:0]               drop_cnt;

  bandpass_level_detector #(.DATA_W(DATA_W), .WIN_LOG2(WIN_LOG2)) dut (
    .clk(clk), .reset(reset), .win_en(win_en), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_max(m_max), .m_min(m_min),
    .m_pk2pk(m_pk2pk), .m_absavg(m_absavg), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int win_q[$];
  bit model_known = 0;
  bit act;
  bit mv;
  int e_max, e_min, e_pk, e_avg, e_drop;

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit we, input bit sv, input int sd,
                            input bit mr);
    bit done;
    int mx, mn, sum;
    done = 0;
    if (rst) begin
      model_known = 1;
      act = 0; mv = 0; win_q.delete();
      e_max = 0; e_min = 0; e_pk = 0; e_avg = 0; e_drop = 0;
      return;
    end
    if (!act) begin
      if (we) begin act = 1; win_q.delete(); end
    end else if (!we) begin
      act = 0; win_q.delete();
    end else if (sv) begin
      win_q.push_back(sd);
      if (win_q.size() == WIN) done = 1;
    end
    if (done) begin
      if (!mv || mr) begin
        mx = -(1 << (DATA_W-1)); mn = (1 << (DATA_W-1)) - 1; sum = 0;
        foreach (win_q[i]) begin
          if (win_q[i] > mx) mx = win_q[i];
          if (win_q[i] < mn) mn = win_q[i];
          sum += (win_q[i] < 0) ? -win_q[i] : win_q[i];
        end
        mv = 1; e_max = mx; e_min = mn; e_pk = mx - mn; e_avg = sum / WIN;
      end else if (e_drop < 255) begin
        e_drop++;
      end
      win_q.delete();
    end else if (mv && mr) begin
      mv = 0;
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input bit rst, input bit we, input bit sv, input int sd, input bit mr);
    reset = rst; win_en = we; s_valid = sv; s_data = DATA_W'(sd); m_ready = mr;
    #1;
    if (model_known) check_eq("s_ready", s_ready, act && we);
    @(posedge clk);
    model_edge(rst, we, sv, sd, mr);
    @(negedge clk);
    check_eq("m_valid", m_valid, mv);
    check_eq("m_max", m_max, e_max);
    check_eq("m_min", m_min, e_min);
    check_eq("m_pk2pk", m_pk2pk, e_pk);
    check_eq("m_absavg", m_absavg, e_avg);
    check_eq("drop_cnt", drop_cnt, e_drop);
  endtask

  task automatic send_win(input int a, input int b, input int c, input int d, input bit mr);
    step(0, 1, 1, a, mr); step(0, 1, 1, b, mr); step(0, 1, 1, c, mr); step(0, 1, 1, d, mr);
  endtask

  initial begin
    reset = 1'b1; win_en = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    @(negedge clk);
    step(1, 0, 0, 0, 0);
    check_eq("rst_valid", m_valid, 0);
    check_eq("rst_drop", drop_cnt, 0);

    step(0, 1, 0, 0, 1);
    send_win(100, -100, 50, -50, 1);
    check_eq("t1_valid", m_valid, 1);
    check_eq("t1_max", m_max, 100);
    check_eq("t1_min", m_min, -100);
    check_eq("t1_pk2pk", m_pk2pk, 200);
    check_eq("t1_absavg", m_absavg, 75);

    send_win(-2048, 2047, 0, 0, 1);
    check_eq("t2_max", m_max, 2047);
    check_eq("t2_min", m_min, -2048);
    check_eq("t2_pk2pk", m_pk2pk, 4095);
    check_eq("t2_absavg", m_absavg, 1023);

    step(0, 1, 1, 1, 1); step(0, 1, 1, 1, 0); step(0, 1, 1, 1, 0); step(0, 1, 1, 1, 0);
    send_win(9, 9, 9, 9, 0);
    check_eq("t3_max_held", m_max, 1);
    check_eq("t3_drop", drop_cnt, 1);
    step(0, 1, 0, 0, 1);
    check_eq("t3_consumed", m_valid, 0);

    send_win(3, 3, 3, 3, 0);
    step(0, 1, 1, 5, 0); step(0, 1, 1, 5, 0); step(0, 1, 1, 5, 0); step(0, 1, 1, 5, 1);
    check_eq("t4_valid", m_valid, 1);
    check_eq("t4_max", m_max, 5);
    check_eq("t4_drop", drop_cnt, 1);

    step(0, 1, 0, 0, 1);
    step(0, 1, 1, 700, 1); step(0, 1, 1, -700, 1);
    step(0, 0, 1, 900, 1);
    check_eq("t5_no_result", m_valid, 0);
    step(0, 1, 0, 0, 1);
    send_win(4, -4, 4, -4, 1);
    check_eq("t5_pk2pk", m_pk2pk, 8);
    check_eq("t5_absavg", m_absavg, 4);

    step(0, 1, 1, 10, 0); step(0, 1, 1, 11, 0); step(0, 1, 1, 12, 0);
    step(1, 1, 0, 0, 0);
    check_eq("t6_valid", m_valid, 0);
    check_eq("t6_max", m_max, 0);
    check_eq("t6_pk2pk", m_pk2pk, 0);
    check_eq("t6_absavg", m_absavg, 0);
    check_eq("t6_drop", drop_cnt, 0);
    check_eq("t6_s_ready", s_ready, 0);

    for (int i = 0; i < 3000; i++) begin
      int sd;
      case ($urandom_range(0, 9))
        0:       sd = -2048;
        1:       sd = 2047;
        default: sd = int'($urandom_range(0, 4095)) - 2048;
      endcase
      step($urandom_range(0, 499) == 0, $urandom_range(0, 39) != 0,
           $urandom_range(0, 9) < 7, sd, $urandom_range(0, 1) == 1);
    end

    for (int i = 0; i < 1100; i++)
      step(0, 1, 1, int'($urandom_range(0, 4095)) - 2048, 0);
    check_eq("sat_drop", drop_cnt, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
